// File: rtl/wb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : wb_line_fetch
// Purpose  : Wishbone master that turns simple CPU rd/wr requests into
//            wishbone cycles. One 16-byte read line is held locally. Read
//            hits are answered from the line. Read misses fetch the line with
//            one 4-beat incrementing burst. Writes go straight through as
//            single beats and are merged into the line when they hit it.
// Ports    : wb_clk, RESET_N           clock, async active-low reset
//            cpu_addr/rd/wr/din/be     client request (level, held to ack)
//            cpu_dout/cpu_ack          client response (one-cycle ack)
//            inval                     one-cycle pulse, drops the held line
//            wb_adr/dat_o/dat_i/sel/cti/stb/cyc/we/ack   wishbone master
//            hit_cnt/miss_cnt          read statistics (WB_LINE_STATS_EN only)
// Options  : define WB_LINE_STATS_EN to add saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_line_fetch #(
    parameter int ADDR_W = 28
`ifdef WB_LINE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              wb_clk,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [31:0]       cpu_din,
    input  logic [3:0]        cpu_be,
    output logic [31:0]       cpu_dout,
    output logic              cpu_ack,
    input  logic              inval,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel,
    output logic [2:0]        wb_cti,
    output logic              wb_stb,
    output logic              wb_cyc,
    output logic              wb_we,
`ifdef WB_LINE_STATS_EN
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] miss_cnt,
`endif
    input  logic              wb_ack
);

    localparam int TAG_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        line_q [4];
    logic [31:0]        line_d [4];
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               valid_q, valid_d;
    logic [1:0]         beat_q, beat_d;
    logic               rd_op_q, rd_op_d;
    // Remembers an inval seen during a fill so the fresh line is discarded
    // once the client has been served.
    logic               pend_q, pend_d;

    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_idx;
    logic               w_hit;
    logic               w_req;

    assign w_tag = cpu_addr[ADDR_W-1:4];
    assign w_idx = cpu_addr[3:2];
    assign w_hit = valid_q && (tag_q == w_tag);
    // The request is still high during the ack cycle; it is not a new one.
    assign w_req = (cpu_rd || cpu_wr) && (state_q != S_RESP);

    always_ff @(posedge wb_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            valid_q <= 1'b0;
            beat_q  <= 2'd0;
            rd_op_q <= 1'b0;
            pend_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
            rd_op_q <= rd_op_d;
            pend_q  <= pend_d;
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        beat_d  = beat_q;
        rd_op_d = rd_op_q;
        pend_d  = pend_q;
        for (int i = 0; i < 4; i++) begin
            line_d[i] = line_q[i];
        end

        cpu_ack  = 1'b0;
        cpu_dout = '0;
        wb_adr   = '0;
        wb_dat_o = '0;
        wb_sel   = 4'h0;
        wb_cti   = 3'd0;
        wb_stb   = 1'b0;
        wb_cyc   = 1'b0;
        wb_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inval) begin
                    valid_d = 1'b0;
                end
                if (w_req) begin
                    if (cpu_wr) begin
                        // A simultaneous read is dropped; the write wins.
                        rd_op_d = 1'b0;
                        state_d = S_WRITE;
                    end else begin
                        rd_op_d = 1'b1;
                        if (w_hit) begin
                            // Hits share the single ack path through RESP,
                            // giving an ack on the very next cycle.
                            state_d = S_RESP;
                        end else begin
                            // The old line is overwritten beat by beat, so
                            // it stops being valid as soon as the fill starts.
                            state_d = S_FILL;
                            beat_d  = 2'd0;
                            valid_d = 1'b0;
                            pend_d  = 1'b0;
                        end
                    end
                end
            end

            S_FILL: begin
                wb_adr = {w_tag, beat_q, 2'b00};
                wb_sel = 4'hF;
                wb_cti = (beat_q == 2'd3) ? 3'd7 : 3'd2;
                wb_stb = 1'b1;
                wb_cyc = 1'b1;
                if (inval) begin
                    pend_d = 1'b1;
                end
                if (wb_ack) begin
                    line_d[beat_q] = wb_dat_i;
                    if (beat_q == 2'd3) begin
                        state_d = S_RESP;
                        tag_d   = w_tag;
                        valid_d = !(pend_q || inval);
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                wb_adr   = cpu_addr;
                wb_dat_o = cpu_din;
                wb_sel   = cpu_be;
                wb_we    = 1'b1;
                wb_stb   = 1'b1;
                wb_cyc   = 1'b1;
                if (inval) begin
                    valid_d = 1'b0;
                end
                if (wb_ack) begin
                    // An earlier inval already cleared valid_q, so checking the
                    // current pulse is enough to suppress the merge.
                    if (w_hit && !inval) begin
                        for (int b = 0; b < 4; b++) begin
                            if (cpu_be[b]) begin
                                line_d[w_idx][8*b +: 8] = cpu_din[8*b +: 8];
                            end
                        end
                    end
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                cpu_ack = 1'b1;
                if (rd_op_q) begin
                    cpu_dout = line_q[w_idx];
                end
                if (inval) begin
                    valid_d = 1'b0;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef WB_LINE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q;
    logic [STAT_W-1:0] miss_cnt_q;
    logic              w_rd_accept;

    assign w_rd_accept = (state_q == S_IDLE) && w_req && !cpu_wr;

    always_ff @(posedge wb_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (w_rd_accept) begin
            if (w_hit) begin
                if (hit_cnt_q != '1) begin
                    hit_cnt_q <= hit_cnt_q + 1'b1;
                end
            end else begin
                if (miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + 1'b1;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_line_fetch
// Purpose  : Self-checking bench for wb_line_fetch with a simple wishbone
//            slave that acks every other cycle and returns {4'hD, addr}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_line_fetch;

    localparam int ADDR_W = 28;

    logic              wb_clk;
    logic              RESET_N;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [31:0]       cpu_din;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_dout;
    logic              cpu_ack;
    logic              inval;
    logic [ADDR_W-1:0] wb_adr;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel;
    logic [2:0]        wb_cti;
    logic              wb_stb;
    logic              wb_cyc;
    logic              wb_we;
    logic              wb_ack;
`ifdef WB_LINE_STATS_EN
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;
`endif

    wb_line_fetch #(.ADDR_W(ADDR_W)) dut (
        .wb_clk   (wb_clk),
        .RESET_N  (RESET_N),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_din  (cpu_din),
        .cpu_be   (cpu_be),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .inval    (inval),
        .wb_adr   (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel   (wb_sel),
        .wb_cti   (wb_cti),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_we    (wb_we),
`ifdef WB_LINE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .wb_ack   (wb_ack)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    function automatic logic [31:0] mem_rd(input logic [ADDR_W-1:0] a);
        return {4'hD, a[ADDR_W-1:2], 2'b00};
    endfunction

    // Wishbone slave: one ack per strobe, every other cycle.
    always @(posedge wb_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            wb_ack   <= 1'b0;
            wb_dat_i <= 32'h0;
        end else if (wb_cyc && wb_stb && !wb_ack) begin
            wb_ack   <= 1'b1;
            wb_dat_i <= wb_we ? 32'h0 : mem_rd(wb_adr);
        end else begin
            wb_ack   <= 1'b0;
        end
    end

    // Beat log of acknowledged wishbone transfers.
    int                nb = 0;
    logic [ADDR_W-1:0] log_adr [8];
    logic [2:0]        log_cti [8];
    logic              log_we  [8];
    logic [3:0]        log_sel [8];
    logic [31:0]       log_dat [8];

    always @(posedge wb_clk) begin
        if (RESET_N && wb_cyc && wb_stb && wb_ack) begin
            if (nb < 8) begin
                log_adr[nb] = wb_adr;
                log_cti[nb] = wb_cti;
                log_we[nb]  = wb_we;
                log_sel[nb] = wb_sel;
                log_dat[nb] = wb_dat_o;
            end
            nb = nb + 1;
        end
    end

    always @(negedge wb_clk) begin
        if (wb_stb && !wb_cyc) viol = viol + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request and wait for its ack. inval_at >= 0 pulses inval for
    // one cycle once that many wishbone beats have been acknowledged.
    task automatic do_req(input logic [ADDR_W-1:0] a, input logic rd, input logic wr,
                          input logic [31:0] din, input logic [3:0] be, input int inval_at,
                          output logic [31:0] dout, output int lat, output logic ack_after);
        logic got;
        logic pulsed;
        got = 1'b0;
        pulsed = 1'b0;
        lat = 0;
        dout = 32'h0;
        @(negedge wb_clk);
        nb = 0;
        cpu_addr = a;
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_din = din;
        cpu_be = be;
        for (int k = 0; k < 40; k++) begin
            @(posedge wb_clk);
            #1;
            lat = lat + 1;
            if (inval) inval = 1'b0;
            if (cpu_ack) begin
                dout = cpu_dout;
                got = 1'b1;
                break;
            end
            if (inval_at >= 0 && !pulsed && nb >= inval_at) begin
                inval = 1'b1;
                pulsed = 1'b1;
            end
        end
        inval = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        chk("ack_seen", {31'h0, got}, 32'h1);
        @(posedge wb_clk);
        #1;
        ack_after = cpu_ack;
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic              wr;
        logic [31:0]       din;
        logic [3:0]        be;
        logic [31:0]       exp_dout;
        int                exp_beats;
        int                exp_lat;
    } vec_t;

    vec_t vt [15];

    task automatic check_vec(input string nm, input vec_t v, input logic [31:0] dout,
                             input int lat, input logic ack_after);
        logic [ADDR_W-1:0] base;
        base = {v.addr[ADDR_W-1:4], 4'h0};
        if (v.rd && !v.wr) begin
            chk({nm, "_dout"}, dout, v.exp_dout);
            if (v.exp_beats == 0) exp_hit = exp_hit + 1;
            else exp_miss = exp_miss + 1;
        end
        chk({nm, "_beats"}, nb, v.exp_beats);
        chk({nm, "_lat"}, lat, v.exp_lat);
        chk({nm, "_ack1cyc"}, {31'h0, ack_after}, 32'h0);
        for (int i = 0; i < v.exp_beats && i < 4 && i < nb; i++) begin
            if (v.wr) begin
                chk({nm, "_wadr"}, {4'h0, log_adr[i]}, {4'h0, v.addr});
                chk({nm, "_wwe"},  {31'h0, log_we[i]}, 32'h1);
                chk({nm, "_wsel"}, {28'h0, log_sel[i]}, {28'h0, v.be});
                chk({nm, "_wcti"}, {29'h0, log_cti[i]}, 32'h0);
                chk({nm, "_wdat"}, log_dat[i], v.din);
            end else begin
                chk({nm, "_fadr"}, {4'h0, log_adr[i]}, {4'h0, base + ADDR_W'(4 * i)});
                chk({nm, "_fwe"},  {31'h0, log_we[i]}, 32'h0);
                chk({nm, "_fsel"}, {28'h0, log_sel[i]}, 32'hF);
                chk({nm, "_fcti"}, {29'h0, log_cti[i]}, (i == 3) ? 32'd7 : 32'd2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dout;
        int          lat;
        logic        ack_after;
        vec_t        v;

        //          addr        rd    wr    din           be     exp_dout      beats lat
        vt[0]  = '{28'h0000100, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000100, 4, 9};
        vt[1]  = '{28'h0000108, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000108, 0, 1};
        vt[2]  = '{28'h000010C, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD000010C, 0, 1};
        vt[3]  = '{28'h0000104, 1'b0, 1'b1, 32'hAABBCCDD, 4'h3, 32'h0,        1, 3};
        vt[4]  = '{28'h0000104, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD000CCDD, 0, 1};
        vt[5]  = '{28'h0000108, 1'b0, 1'b1, 32'h12345678, 4'h0, 32'h0,        1, 3};
        vt[6]  = '{28'h0000108, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000108, 0, 1};
        vt[7]  = '{28'h0000304, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0,        1, 3};
        vt[8]  = '{28'h0000100, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000100, 0, 1};
        vt[9]  = '{28'h0000204, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000204, 4, 9};
        vt[10] = '{28'h0000100, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000100, 4, 9};
        vt[11] = '{28'h000010C, 1'b0, 1'b1, 32'h11223344, 4'hC, 32'h0,        1, 3};
        vt[12] = '{28'h000010C, 1'b1, 1'b0, 32'h0,        4'h0, 32'h1122010C, 0, 1};
        vt[13] = '{28'h0000300, 1'b1, 1'b1, 32'h55667788, 4'hF, 32'h0,        1, 3};
        vt[14] = '{28'h0000100, 1'b1, 1'b0, 32'h0,        4'h0, 32'hD0000100, 0, 1};

        RESET_N  = 1'b0;
        cpu_addr = '0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_din  = 32'h0;
        cpu_be   = 4'h0;
        inval    = 1'b0;
        repeat (3) @(negedge wb_clk);

        chk("rst_ack",  {31'h0, cpu_ack}, 32'h0);
        chk("rst_dout", cpu_dout, 32'h0);
        chk("rst_cyc",  {31'h0, wb_cyc}, 32'h0);
        chk("rst_stb",  {31'h0, wb_stb}, 32'h0);
        chk("rst_we",   {31'h0, wb_we}, 32'h0);
        chk("rst_adr",  {4'h0, wb_adr}, 32'h0);
        chk("rst_sel",  {28'h0, wb_sel}, 32'h0);
        chk("rst_cti",  {29'h0, wb_cti}, 32'h0);
        RESET_N = 1'b1;
        repeat (2) @(negedge wb_clk);

        for (int i = 0; i < 15; i++) begin
            v = vt[i];
            do_req(v.addr, v.rd, v.wr, v.din, v.be, -1, dout, lat, ack_after);
            check_vec($sformatf("vec%0d", i), v, dout, lat, ack_after);
        end
`ifdef WB_LINE_STATS_EN
        chk("hit_cnt_a",  {16'h0, hit_cnt},  exp_hit);
        chk("miss_cnt_a", {16'h0, miss_cnt}, exp_miss);
`endif

        // inval while idle drops the line: 0x100 must miss again.
        @(negedge wb_clk);
        inval = 1'b1;
        @(negedge wb_clk);
        inval = 1'b0;
        v = '{28'h0000100, 1'b1, 1'b0, 32'h0, 4'h0, 32'hD0000100, 4, 9};
        do_req(v.addr, v.rd, v.wr, v.din, v.be, -1, dout, lat, ack_after);
        check_vec("inval_idle", v, dout, lat, ack_after);

        // inval mid-burst: the read still completes, then the line is gone.
        v = '{28'h0000200, 1'b1, 1'b0, 32'h0, 4'h0, 32'hD0000200, 4, 9};
        do_req(v.addr, v.rd, v.wr, v.din, v.be, 2, dout, lat, ack_after);
        check_vec("inval_fill", v, dout, lat, ack_after);
        do_req(v.addr, v.rd, v.wr, v.din, v.be, -1, dout, lat, ack_after);
        check_vec("reread_200", v, dout, lat, ack_after);

        // inval during a hitting write: no merge, line cleared.
        v = '{28'h0000204, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 3};
        do_req(v.addr, v.rd, v.wr, v.din, v.be, 0, dout, lat, ack_after);
        check_vec("inval_write", v, dout, lat, ack_after);
        v = '{28'h0000204, 1'b1, 1'b0, 32'h0, 4'h0, 32'hD0000204, 4, 9};
        do_req(v.addr, v.rd, v.wr, v.din, v.be, -1, dout, lat, ack_after);
        check_vec("after_inval_wr", v, dout, lat, ack_after);

        // Reset after the 2nd beat of a miss burst.
        @(negedge wb_clk);
        nb = 0;
        cpu_addr = 28'h0000400;
        cpu_rd = 1'b1;
        for (int k = 0; k < 40 && nb < 2; k++) begin
            @(posedge wb_clk);
            #1;
        end
        chk("rst_mid_beats", nb, 2);
        chk("rst_mid_cyc_before", {31'h0, wb_cyc}, 32'h1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("rst_mid_stb", {31'h0, wb_stb}, 32'h0);
        chk("rst_mid_ack", {31'h0, cpu_ack}, 32'h0);
        cpu_rd = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        repeat (2) @(negedge wb_clk);
        RESET_N = 1'b1;
        @(negedge wb_clk);
        v = '{28'h0000200, 1'b1, 1'b0, 32'h0, 4'h0, 32'hD0000200, 4, 9};
        do_req(v.addr, v.rd, v.wr, v.din, v.be, -1, dout, lat, ack_after);
        check_vec("after_reset", v, dout, lat, ack_after);
`ifdef WB_LINE_STATS_EN
        chk("hit_cnt_b",  {16'h0, hit_cnt},  exp_hit);
        chk("miss_cnt_b", {16'h0, miss_cnt}, exp_miss);
`endif

        chk("stb_without_cyc", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
